// File: rtl/fpmul_pkg.sv
// rtl/fpmul_pkg.sv - shared types and constants for the binary32 multiplier
package fpmul_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_NORM = 2'd2
   } state_t;

   localparam int          BIAS     = 127;
   localparam int          EXP_MAX  = 255;
   localparam logic [31:0] QNAN     = 32'h7FC0_0000;
   localparam int          MANT_W   = 24;
   localparam logic [4:0]  LAST_BIT = 5'(MANT_W - 1);

endpackage

// File: rtl/fpmul_shift_add.sv
// rtl/fpmul_shift_add.sv - 24x24 shift-add mantissa accumulator, one multiplier bit per step
module fpmul_shift_add
   import fpmul_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              step,
   input  logic [MANT_W-1:0] ma,
   input  logic [MANT_W-1:0] mb,
   output logic [4:0]        idx,
   output logic [MANT_W:0]   prod_hi
);

   logic [MANT_W-1:0]   ma_q, ma_d;
   logic [MANT_W-1:0]   mb_q, mb_d;
   logic [4:0]          cnt_q, cnt_d;
   logic [2*MANT_W-1:0] acc_q, acc_d;

   // Load operands on start; otherwise add the shifted multiplicand for each set multiplier bit, LSB first
   always_comb begin
      ma_d  = ma_q;
      mb_d  = mb_q;
      cnt_d = cnt_q;
      acc_d = acc_q;
      if (start) begin
         ma_d  = ma;
         mb_d  = mb;
         cnt_d = 5'd0;
         acc_d = '0;
      end else if (step) begin
         if (mb_q[cnt_q]) begin
            acc_d = acc_q + ({{MANT_W{1'b0}}, ma_q} << cnt_q);
         end
         cnt_d = cnt_q + 5'd1;
      end
   end

   // Accumulator state; reset discards any partial product
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ma_q  <= '0;
         mb_q  <= '0;
         cnt_q <= '0;
         acc_q <= '0;
      end else begin
         ma_q  <= ma_d;
         mb_q  <= mb_d;
         cnt_q <= cnt_d;
         acc_q <= acc_d;
      end
   end

   // Only the top 25 product bits matter to truncating normalization
   assign idx     = cnt_q;
   assign prod_hi = acc_q[2*MANT_W-1:MANT_W-1];

endmodule

// File: rtl/fpmul_core.sv
// rtl/fpmul_core.sv - iterative binary32 multiplier with fixed 25-cycle latency
module fpmul_core
   import fpmul_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        go,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] p,
   output logic        busy,
   output logic        done
);

   state_t state_q, state_d;

   logic        sign_q, sign_d;
   logic [7:0]  ea_q, ea_d;
   logic [7:0]  eb_q, eb_d;
   logic        nan_q, nan_d;
   logic        inf_q, inf_d;
   logic        zero_q, zero_d;
   logic [31:0] p_q, p_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic              accept;
   logic [4:0]        idx;
   logic [MANT_W:0]   prod_hi;
   logic [MANT_W-1:0] ma_in, mb_in;

   logic a_exp_max, b_exp_max, a_exp_zero, b_exp_zero, a_frac_nz, b_frac_nz;
   logic [9:0]  e_norm;
   logic [22:0] frac;

   assign accept = (state_q == S_IDLE) && go;

   assign a_exp_max  = (a[30:23] == 8'(EXP_MAX));
   assign b_exp_max  = (b[30:23] == 8'(EXP_MAX));
   assign a_exp_zero = (a[30:23] == 8'd0);
   assign b_exp_zero = (b[30:23] == 8'd0);
   assign a_frac_nz  = |a[22:0];
   assign b_frac_nz  = |b[22:0];
   assign ma_in      = {!a_exp_zero, a[22:0]};
   assign mb_in      = {!b_exp_zero, b[22:0]};

   fpmul_shift_add u_shift_add (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (accept),
      .step    (state_q == S_MUL),
      .ma      (ma_in),
      .mb      (mb_in),
      .idx     (idx),
      .prod_hi (prod_hi)
   );

   // Exponent as 10-bit signed so both overflow and underflow stay visible; bump when the product is >= 2.0
   assign e_norm = {2'b00, ea_q} + {2'b00, eb_q} - 10'(BIAS) + {9'd0, prod_hi[MANT_W]};
   assign frac   = prod_hi[MANT_W] ? prod_hi[MANT_W-1:1] : prod_hi[MANT_W-2:0];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next state: MUL runs exactly 24 iterations, NORM always lasts one cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (go) state_d = S_MUL;
         S_MUL:   if (idx == LAST_BIT) state_d = S_NORM;
         S_NORM:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Operand capture/classification on accept, result packing in NORM
   always_comb begin
      sign_d = sign_q;
      ea_d   = ea_q;
      eb_d   = eb_q;
      nan_d  = nan_q;
      inf_d  = inf_q;
      zero_d = zero_q;
      p_d    = p_q;
      busy_d = busy_q;
      done_d = done_q;
      if (accept) begin
         sign_d = a[31] ^ b[31];
         ea_d   = a[30:23];
         eb_d   = b[30:23];
         nan_d  = (a_exp_max && a_frac_nz) || (b_exp_max && b_frac_nz) ||
                  (a_exp_max && b_exp_zero) || (b_exp_max && a_exp_zero);
         inf_d  = a_exp_max || b_exp_max;
         zero_d = a_exp_zero || b_exp_zero;
         busy_d = 1'b1;
         done_d = 1'b0;
      end else if (state_q == S_NORM) begin
         busy_d = 1'b0;
         done_d = 1'b1;
         if (nan_q)                                        p_d = QNAN;
         else if (inf_q)                                   p_d = {sign_q, 8'hFF, 23'd0};
         else if (zero_q)                                  p_d = {sign_q, 31'd0};
         else if (!e_norm[9] && (e_norm >= 10'(EXP_MAX)))  p_d = {sign_q, 8'hFF, 23'd0};
         else if (e_norm[9] || (e_norm == 10'd0))          p_d = {sign_q, 31'd0};
         else                                              p_d = {sign_q, e_norm[7:0], frac};
      end
   end

   // Datapath and status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign_q <= 1'b0;
         ea_q   <= '0;
         eb_q   <= '0;
         nan_q  <= 1'b0;
         inf_q  <= 1'b0;
         zero_q <= 1'b0;
         p_q    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         sign_q <= sign_d;
         ea_q   <= ea_d;
         eb_q   <= eb_d;
         nan_q  <= nan_d;
         inf_q  <= inf_d;
         zero_q <= zero_d;
         p_q    <= p_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign p    = p_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_fpmul_core.sv
// tb/tb_fpmul_core.sv - randomized and directed self-checking bench for fpmul_core
module tb_fpmul_core;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        go = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [31:0] p;
   logic        busy;
   logic        done;

   int total = 0;
   int bad   = 0;

   fpmul_core dut (
      .clk   (clk),
      .rst_n (rst_n),
      .go    (go),
      .a     (a),
      .b     (b),
      .p     (p),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
      int     ex, ey, e;
      longint mx, my, m, fr;
      logic   s, xnan, ynan, xinf, yinf, xzero, yzero;
      logic [31:0] r;
      s     = x[31] ^ y[31];
      ex    = int'(x[30:23]);
      ey    = int'(y[30:23]);
      xnan  = (ex == 255) && (x[22:0] != 0);
      ynan  = (ey == 255) && (y[22:0] != 0);
      xinf  = (ex == 255) && (x[22:0] == 0);
      yinf  = (ey == 255) && (y[22:0] == 0);
      xzero = (ex == 0);
      yzero = (ey == 0);
      if (xnan || ynan || (xinf && yzero) || (yinf && xzero)) return 32'h7FC00000;
      if (xinf || yinf) return {s, 8'hFF, 23'd0};
      if (xzero || yzero) return {s, 31'd0};
      mx = longint'(x[22:0]) + 64'sd8388608;
      my = longint'(y[22:0]) + 64'sd8388608;
      m  = mx * my;
      e  = ex + ey - 127;
      if (m >= (64'sd1 <<< 47)) begin
         fr = (m >>> 24) % 64'sd8388608;
         e  = e + 1;
      end else begin
         fr = (m >>> 23) % 64'sd8388608;
      end
      if (e >= 255) return {s, 8'hFF, 23'd0};
      if (e <= 0) return {s, 31'd0};
      r = {s, 8'(e), 23'(fr)};
      return r;
   endfunction

   // Issue one operation and check busy/done, latency and result
   task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y);
      int n;
      @(negedge clk);
      a  = x;
      b  = y;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      a  = $urandom;
      b  = $urandom;
      check_eq({tag, ".busy_on"}, 32'(busy), 32'd1);
      check_eq({tag, ".done_clr"}, 32'(done), 32'd0);
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, ".latency"}, 32'(n), 32'd25);
      check_eq({tag, ".busy_off"}, 32'(busy), 32'd0);
      check_eq({tag, ".p"}, p, ref_mul(x, y));
   endtask

   logic [31:0] ra, rb, first_p;
   int          n;
   logic        early_done;

   initial begin
      #1;
      check_eq("rst.p", p, 32'd0);
      check_eq("rst.busy", 32'(busy), 32'd0);
      check_eq("rst.done", 32'(done), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors, literal expectations
      run_op("mul_1p5x2", 32'h3FC00000, 32'h40000000);
      check_eq("lit_1p5x2", p, 32'h40400000);
      run_op("mul_m2xhalf", 32'hC0000000, 32'h3F000000);
      check_eq("lit_m2xhalf", p, 32'hBF800000);
      run_op("negzero", 32'h80000000, 32'h3F800000);
      check_eq("lit_negzero", p, 32'h80000000);
      run_op("ovf", 32'h7F000000, 32'h7F000000);
      check_eq("lit_ovf", p, 32'h7F800000);
      run_op("unf", 32'h00800000, 32'h00800000);
      check_eq("lit_unf", p, 32'h00000000);
      run_op("denorm", 32'h00400000, 32'h3F800000);
      check_eq("lit_denorm", p, 32'h00000000);
      run_op("nan", 32'h7FC00000, 32'h3F800000);
      check_eq("lit_nan", p, 32'h7FC00000);
      run_op("infxzero", 32'h7F800000, 32'h00000000);
      check_eq("lit_infxzero", p, 32'h7FC00000);
      run_op("neginf", 32'hFF800000, 32'h40000000);
      check_eq("lit_neginf", p, 32'hFF800000);

      // Result holds while idle
      repeat (3) @(negedge clk);
      check_eq("hold.p", p, 32'hFF800000);

      // Random operands: mostly normal exponents, occasional specials and extremes
      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: ra[30:23] = 8'($urandom_range(0, 1) ? 255 : 0);
            1: begin ra[30:23] = 8'($urandom_range(200, 254)); rb[30:23] = 8'($urandom_range(150, 254)); end
            2: begin ra[30:23] = 8'($urandom_range(1, 60)); rb[30:23] = 8'($urandom_range(1, 70)); end
            default: begin ra[30:23] = 8'($urandom_range(90, 165)); rb[30:23] = 8'($urandom_range(90, 165)); end
         endcase
         run_op("rand", ra, rb);
      end

      // go while busy (with new operands) is ignored; go on the completion edge is ignored
      @(negedge clk);
      a = 32'h3FC00000; b = 32'h40000000; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      early_done = 1'b0;
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         if (k == 10) begin
            a = 32'h40400000; b = 32'h40400000; go = 1'b1;
         end else if (k == 11) begin
            go = 1'b0;
         end
         if (done) early_done = 1'b1;
      end
      check_eq("ign.no_early_done", 32'(early_done), 32'd0);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      check_eq("ign.done", 32'(done), 32'd1);
      check_eq("ign.p", p, 32'h40400000);
      repeat (2) @(negedge clk);
      check_eq("ign.no_restart_busy", 32'(busy), 32'd0);
      check_eq("ign.no_restart_done", 32'(done), 32'd1);

      // Asynchronous reset mid-MUL discards the operation
      @(negedge clk);
      a = 32'hC0000000; b = 32'h3F000000; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst.p", p, 32'd0);
      check_eq("arst.busy", 32'(busy), 32'd0);
      check_eq("arst.done", 32'(done), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      while (n < 30) begin
         @(negedge clk);
         n++;
      end
      check_eq("arst.idle_done", 32'(done), 32'd0);
      run_op("post_rst", 32'h3FC00000, 32'h40000000);
      check_eq("lit_post_rst", p, 32'h40400000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1);
   end

endmodule

// File: doc/fpmul_core.md
# fpmul_core

Iterative IEEE-754 binary32 multiplier behind the memory-mapped FP-multiply peripheral. Consumes the operand A, operand B and control registers written through the peripheral's address decoder (we0/we1/we2). Produces the product and status words that the decoder's RdSel path returns to the CPU. Shift-add mantissa datapath, fixed 25-cycle latency, truncating rounding, no denormal support.

## Interface
- Parameters: none; format fixed at binary32 (1/8/23).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- go  in  1  start pulse from control-register write; sampled only in IDLE
- a  in  32  operand A register value
- b  in  32  operand B register value
- p  out  32  product; holds last result until next completion or reset
- busy  out  1  high from go acceptance until completion
- done  out  1  sticky status; set on completion, cleared on next accepted go

## Operation
- FSM states:
  - IDLE: go=1 → MUL.
  - MUL: stay while count<23; at count=23 → NORM.
  - NORM → IDLE, unconditional.
- Accept (IDLE, go=1):
  - latch sign sa^sb, exponents, mantissas with hidden bit (24 bits);
  - classify specials;
  - count=0, acc=0, busy=1, done=0.
- MUL, one multiplier bit per cycle, LSB first:
  - if mb[count], acc += ma<<count (48-bit acc);
  - count++.
- NORM:
  - e = ea+eb-127, 10-bit signed;
  - acc[47]=1: frac=acc[46:24], e+1; else frac=acc[45:23];
  - truncate, no rounding.
- Result priority, evaluated in NORM:
  1. Any NaN input (exp=255, frac≠0), or inf×zero → 0x7FC00000.
  2. Any inf input → {s, 0xFF, 0}.
  3. Any zero or denormal input (exp=0) → {s, 0}; denormals flush to signed zero.
  4. e≥255 → {s, 0xFF, 0}.
  5. e≤0 → {s, 0}.
  6. Otherwise {s, e[7:0], frac}.
- Special cases still run the full 25-cycle sequence; latency never depends on data.
- go while busy: ignored, no queuing. a/b changes after acceptance: no effect.
- Reset, any state including mid-MUL:
  - state=IDLE, p=0, busy=0, done=0, count=0, acc=0;
  - any in-flight operation is discarded.

## Timing
- Edge E0: go accepted; busy=1 and done=0 visible after E0.
- Edges E1..E24: MUL iterations.
- Edge E25: NORM; p updated, done=1, busy=0 all visible after E25.
- Go-accept to done = 25 cycles. Back-to-back: go accepted at E25+1 earliest.
- go=1 on the same edge as completion (state NORM): ignored. Must be reasserted in IDLE.
- done and p are register outputs; no combinational path from inputs.

## Structure
- Package fpmul_pkg holds:
  - state encoding (IDLE, MUL, NORM);
  - constants BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, MANT_W=24.
- Sub-module fpmul_shift_add: 24×24 iterative accumulator with start, bit index and 48-bit product.
- Top fpmul_core holds the FSM, operand classification, exponent arithmetic, normalization and packing.

## Test plan
- 0x3FC00000 × 0x40000000 (1.5×2.0) → p=0x40400000, done exactly 25 cycles after go, busy low with done.
- 0xC0000000 × 0x3F000000 (−2.0×0.5) → p=0xBF800000; 0x80000000 × 0x3F800000 → p=0x80000000 (signed zero).
- Overflow and underflow:
  - 0x7F000000 × 0x7F000000 → 0x7F800000;
  - 0x00800000 × 0x00800000 → 0x00000000;
  - 0x00400000 (denormal) × 0x3F800000 → 0x00000000.
- Specials:
  - 0x7FC00000 × 0x3F800000 → 0x7FC00000;
  - 0x7F800000 × 0x00000000 → 0x7FC00000;
  - 0xFF800000 × 0x40000000 → 0xFF800000.
- Pulse go again at cycle 10 of a run while changing a/b → ignored; first result unchanged at cycle 25; done stays 0 until then.
- Deassert rst_n at MUL cycle 10 → p=0, busy=0, done=0 immediately. After release, a fresh go with 1.5×2.0 completes normally in 25 cycles.
